// File: rtl/cpu_pipe_pkg.sv
// Shared pipeline definitions: control-bundle layout, field widths and the
// ID/EX flush-pending state encoding.
package cpu_pipe_pkg;

    localparam int CTRL_W  = 7;
    localparam int FUNCT_W = 10;
    localparam int REG_AW  = 5;

    // Bit positions inside the {RegWrite,MemtoReg,MemRead,MemWrite,ALUOp[1:0],ALUSrc} bundle
    localparam int CTRL_REGWRITE = 6;
    localparam int CTRL_MEMTOREG = 5;
    localparam int CTRL_MEMREAD  = 4;
    localparam int CTRL_MEMWRITE = 3;
    localparam int CTRL_ALUOP_HI = 2;
    localparam int CTRL_ALUOP_LO = 1;
    localparam int CTRL_ALUSRC   = 0;

    typedef struct packed {
        logic       reg_write;
        logic       mem_to_reg;
        logic       mem_read;
        logic       mem_write;
        logic [1:0] alu_op;
        logic       alu_src;
    } ctrl_t;

    localparam logic [0:0] FP_IDLE = 1'b0;
    localparam logic [0:0] FP_PEND = 1'b1;

endpackage

// File: rtl/pipe_event_counter.sv
// Saturating event counter with synchronous active-low clear; sticks at all-ones.
module pipe_event_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk_i,
    input  logic             clr_n_i,
    input  logic             inc_i,
    output logic [CNT_W-1:0] count_o
);

    localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    always_ff @(posedge clk_i) begin
        if (!clr_n_i) begin
            count_o <= '0;
        end else if (inc_i && (count_o != '1)) begin
            count_o <= count_o + ONE;
        end
    end

endmodule

// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register with load-use bubbles, branch flush and memory-busy hold.
// Define ID_EX_PERF_CNT_EN to build the bubble/hold performance counters.
module id_ex_pipe_reg #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5,
    parameter int CNT_W  = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              Stall_i,
    input  logic              NoOp_i,
    input  logic              Flush_i,
    input  logic [6:0]        ID_Ctrl_i,
    input  logic [XLEN-1:0]   ID_PC_i,
    input  logic [XLEN-1:0]   ID_RS1data_i,
    input  logic [XLEN-1:0]   ID_RS2data_i,
    input  logic [XLEN-1:0]   ID_Imm_i,
    input  logic [9:0]        ID_Funct_i,
    input  logic [REG_AW-1:0] ID_RS1addr_i,
    input  logic [REG_AW-1:0] ID_RS2addr_i,
    input  logic [REG_AW-1:0] ID_RDaddr_i,
    output logic              EX_Valid_o,
    output logic [6:0]        EX_Ctrl_o,
    output logic              EX_RegWrite_o,
    output logic              EX_MemtoReg_o,
    output logic              EX_MemRead_o,
    output logic              EX_MemWrite_o,
    output logic [1:0]        EX_ALUOp_o,
    output logic              EX_ALUSrc_o,
    output logic [XLEN-1:0]   EX_PC_o,
    output logic [XLEN-1:0]   EX_RS1data_o,
    output logic [XLEN-1:0]   EX_RS2data_o,
    output logic [XLEN-1:0]   EX_Imm_o,
    output logic [9:0]        EX_Funct_o,
    output logic [REG_AW-1:0] EX_RS1addr_o,
    output logic [REG_AW-1:0] EX_RS2addr_o,
    output logic [REG_AW-1:0] EX_RDaddr_o,
    output logic [CNT_W-1:0]  Bubble_cnt_o,
    output logic [CNT_W-1:0]  Hold_cnt_o,
    output logic              Flush_pend_o
);

    import cpu_pipe_pkg::*;

    ctrl_t      ctrl_q;
    logic [0:0] flush_pend_q;
    logic       bubble_load;

    // A flush seen during a hold is remembered and turns the first free edge into a bubble.
    assign bubble_load = !Stall_i && (Flush_i || NoOp_i || (flush_pend_q == FP_PEND));

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            EX_Valid_o   <= 1'b0;
            ctrl_q       <= '0;
            EX_PC_o      <= '0;
            EX_RS1data_o <= '0;
            EX_RS2data_o <= '0;
            EX_Imm_o     <= '0;
            EX_Funct_o   <= '0;
            EX_RS1addr_o <= '0;
            EX_RS2addr_o <= '0;
            EX_RDaddr_o  <= '0;
            flush_pend_q <= FP_IDLE;
        end else if (Stall_i) begin
            if (Flush_i) begin
                flush_pend_q <= FP_PEND;
            end
        end else if (bubble_load) begin
            // rd=0 on a bubble keeps forwarding from ever matching it
            EX_Valid_o   <= 1'b0;
            ctrl_q       <= '0;
            EX_PC_o      <= '0;
            EX_RS1data_o <= '0;
            EX_RS2data_o <= '0;
            EX_Imm_o     <= '0;
            EX_Funct_o   <= '0;
            EX_RS1addr_o <= '0;
            EX_RS2addr_o <= '0;
            EX_RDaddr_o  <= '0;
            flush_pend_q <= FP_IDLE;
        end else begin
            EX_Valid_o   <= 1'b1;
            ctrl_q       <= ID_Ctrl_i;
            EX_PC_o      <= ID_PC_i;
            EX_RS1data_o <= ID_RS1data_i;
            EX_RS2data_o <= ID_RS2data_i;
            EX_Imm_o     <= ID_Imm_i;
            EX_Funct_o   <= ID_Funct_i;
            EX_RS1addr_o <= ID_RS1addr_i;
            EX_RS2addr_o <= ID_RS2addr_i;
            EX_RDaddr_o  <= ID_RDaddr_i;
            flush_pend_q <= FP_IDLE;
        end
    end

    assign EX_Ctrl_o     = ctrl_q;
    assign EX_RegWrite_o = EX_Ctrl_o[CTRL_REGWRITE];
    assign EX_MemtoReg_o = EX_Ctrl_o[CTRL_MEMTOREG];
    assign EX_MemRead_o  = EX_Ctrl_o[CTRL_MEMREAD];
    assign EX_MemWrite_o = EX_Ctrl_o[CTRL_MEMWRITE];
    assign EX_ALUOp_o    = EX_Ctrl_o[CTRL_ALUOP_HI:CTRL_ALUOP_LO];
    assign EX_ALUSrc_o   = EX_Ctrl_o[CTRL_ALUSRC];
    assign Flush_pend_o  = flush_pend_q[0];

`ifdef ID_EX_PERF_CNT_EN
    pipe_event_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
        .clk_i   (clk_i),
        .clr_n_i (rst_i),
        .inc_i   (bubble_load),
        .count_o (Bubble_cnt_o)
    );

    pipe_event_counter #(.CNT_W(CNT_W)) u_hold_cnt (
        .clk_i   (clk_i),
        .clr_n_i (rst_i),
        .inc_i   (Stall_i),
        .count_o (Hold_cnt_o)
    );
`else
    assign Bubble_cnt_o = '0;
    assign Hold_cnt_o   = '0;
`endif

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Bench for id_ex_pipe_reg: directed vector table, randomized run against a
// behavioural model, and counter saturation sequences (CNT_W=4 instance).
module tb_id_ex_pipe_reg;

    localparam int TB_CNT_W = 4;
    localparam int CNT_MAX  = (1 << TB_CNT_W) - 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, stall, noop, flush;
    logic [6:0]  id_ctrl;
    logic [31:0] id_pc, id_rs1d, id_rs2d, id_imm;
    logic [9:0]  id_funct;
    logic [4:0]  id_rs1a, id_rs2a, id_rd;

    logic        ex_valid;
    logic [6:0]  ex_ctrl;
    logic        ex_regwrite, ex_memtoreg, ex_memread, ex_memwrite, ex_alusrc;
    logic [1:0]  ex_aluop;
    logic [31:0] ex_pc, ex_rs1d, ex_rs2d, ex_imm;
    logic [9:0]  ex_funct;
    logic [4:0]  ex_rs1a, ex_rs2a, ex_rd;
    logic [TB_CNT_W-1:0] bubble_cnt, hold_cnt;
    logic        flush_pend;

    id_ex_pipe_reg #(.XLEN(32), .REG_AW(5), .CNT_W(TB_CNT_W)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .Stall_i      (stall),
        .NoOp_i       (noop),
        .Flush_i      (flush),
        .ID_Ctrl_i    (id_ctrl),
        .ID_PC_i      (id_pc),
        .ID_RS1data_i (id_rs1d),
        .ID_RS2data_i (id_rs2d),
        .ID_Imm_i     (id_imm),
        .ID_Funct_i   (id_funct),
        .ID_RS1addr_i (id_rs1a),
        .ID_RS2addr_i (id_rs2a),
        .ID_RDaddr_i  (id_rd),
        .EX_Valid_o   (ex_valid),
        .EX_Ctrl_o    (ex_ctrl),
        .EX_RegWrite_o(ex_regwrite),
        .EX_MemtoReg_o(ex_memtoreg),
        .EX_MemRead_o (ex_memread),
        .EX_MemWrite_o(ex_memwrite),
        .EX_ALUOp_o   (ex_aluop),
        .EX_ALUSrc_o  (ex_alusrc),
        .EX_PC_o      (ex_pc),
        .EX_RS1data_o (ex_rs1d),
        .EX_RS2data_o (ex_rs2d),
        .EX_Imm_o     (ex_imm),
        .EX_Funct_o   (ex_funct),
        .EX_RS1addr_o (ex_rs1a),
        .EX_RS2addr_o (ex_rs2a),
        .EX_RDaddr_o  (ex_rd),
        .Bubble_cnt_o (bubble_cnt),
        .Hold_cnt_o   (hold_cnt),
        .Flush_pend_o (flush_pend)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: what EX should hold, kept as plain variables and counts
    logic        m_valid, m_pend;
    logic [6:0]  m_ctrl;
    logic [31:0] m_pc, m_rs1d, m_rs2d, m_imm;
    logic [9:0]  m_funct;
    logic [4:0]  m_rs1a, m_rs2a, m_rd;
    int          m_bub, m_hold;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h @%0t", name, act, exp, $time);
        end
    endfunction

    function automatic logic [31:0] cnt_exp(int v);
`ifdef ID_EX_PERF_CNT_EN
        return v;
`else
        return (v == 0) ? 32'd0 : 32'd0;
`endif
    endfunction

    function automatic void clear_model_fields();
        m_valid = 1'b0; m_ctrl = '0; m_pc = '0; m_rs1d = '0; m_rs2d = '0;
        m_imm = '0; m_funct = '0; m_rs1a = '0; m_rs2a = '0; m_rd = '0;
    endfunction

    function automatic void model_step();
        if (!rst) begin
            clear_model_fields();
            m_pend = 1'b0; m_bub = 0; m_hold = 0;
        end else if (stall) begin
            if (m_hold < CNT_MAX) m_hold++;
            if (flush) m_pend = 1'b1;
        end else if (flush || noop || m_pend) begin
            clear_model_fields();
            m_pend = 1'b0;
            if (m_bub < CNT_MAX) m_bub++;
        end else begin
            m_valid = 1'b1; m_ctrl = id_ctrl; m_pc = id_pc; m_rs1d = id_rs1d;
            m_rs2d = id_rs2d; m_imm = id_imm; m_funct = id_funct;
            m_rs1a = id_rs1a; m_rs2a = id_rs2a; m_rd = id_rd;
        end
    endfunction

    function automatic void check_all(string tag);
        check({tag, ".valid"},    {31'd0, ex_valid},    {31'd0, m_valid});
        check({tag, ".ctrl"},     {25'd0, ex_ctrl},     {25'd0, m_ctrl});
        check({tag, ".regwrite"}, {31'd0, ex_regwrite}, {31'd0, m_ctrl[6]});
        check({tag, ".memtoreg"}, {31'd0, ex_memtoreg}, {31'd0, m_ctrl[5]});
        check({tag, ".memread"},  {31'd0, ex_memread},  {31'd0, m_ctrl[4]});
        check({tag, ".memwrite"}, {31'd0, ex_memwrite}, {31'd0, m_ctrl[3]});
        check({tag, ".aluop"},    {30'd0, ex_aluop},    {30'd0, m_ctrl[2:1]});
        check({tag, ".alusrc"},   {31'd0, ex_alusrc},   {31'd0, m_ctrl[0]});
        check({tag, ".pc"},       ex_pc,                m_pc);
        check({tag, ".rs1data"},  ex_rs1d,              m_rs1d);
        check({tag, ".rs2data"},  ex_rs2d,              m_rs2d);
        check({tag, ".imm"},      ex_imm,               m_imm);
        check({tag, ".funct"},    {22'd0, ex_funct},    {22'd0, m_funct});
        check({tag, ".rs1addr"},  {27'd0, ex_rs1a},     {27'd0, m_rs1a});
        check({tag, ".rs2addr"},  {27'd0, ex_rs2a},     {27'd0, m_rs2a});
        check({tag, ".rdaddr"},   {27'd0, ex_rd},       {27'd0, m_rd});
        check({tag, ".pend"},     {31'd0, flush_pend},  {31'd0, m_pend});
        check({tag, ".bubble"},   {28'd0, bubble_cnt},  cnt_exp(m_bub));
        check({tag, ".hold"},     {28'd0, hold_cnt},    cnt_exp(m_hold));
    endfunction

    task automatic step(string tag);
        model_step();
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic drive(logic r, logic s, logic n, logic f, logic [6:0] c,
                         logic [4:0] rd, logic [31:0] d);
        rst = r; stall = s; noop = n; flush = f; id_ctrl = c; id_rd = rd;
        id_rs1d = d; id_pc = d ^ 32'h0000_1000; id_rs2d = ~d; id_imm = {d[30:0], 1'b1};
        id_funct = d[9:0]; id_rs1a = rd ^ 5'h01; id_rs2a = rd ^ 5'h02;
    endtask

    typedef struct {
        logic        rst, stall, noop, flush;
        logic [6:0]  ctrl;
        logic [4:0]  rd;
        logic [31:0] data;
        logic        e_valid;
        logic [6:0]  e_ctrl;
        logic [4:0]  e_rd;
        logic [31:0] e_data;
        int          e_bub, e_hold;
        logic        e_pend;
    } vec_t;

    vec_t vecs[15];

    initial begin
        m_bub = 0; m_hold = 0; m_pend = 1'b0;
        clear_model_fields();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 7'h00, 5'd0, 32'h0);

        //          rst  stl  nop  fl   ctrl   rd  data            valid ctrl  rd  data          bub hold pend
        vecs[0]  = '{1'b0,1'b1,1'b1,1'b1,7'h7f,5'd31,32'hffff_ffff, 1'b0,7'h00,5'd0, 32'h0,        0, 0, 1'b0};
        vecs[1]  = '{1'b1,1'b0,1'b0,1'b0,7'h50,5'd5, 32'h0000_1234, 1'b1,7'h50,5'd5, 32'h1234,     0, 0, 1'b0};
        vecs[2]  = '{1'b1,1'b0,1'b1,1'b0,7'h7f,5'd6, 32'h0000_5555, 1'b0,7'h00,5'd0, 32'h0,        1, 0, 1'b0};
        vecs[3]  = '{1'b1,1'b0,1'b0,1'b0,7'h42,5'd7, 32'h0000_aaaa, 1'b1,7'h42,5'd7, 32'haaaa,     1, 0, 1'b0};
        vecs[4]  = '{1'b1,1'b1,1'b0,1'b0,7'h01,5'd9, 32'h0000_0001, 1'b1,7'h42,5'd7, 32'haaaa,     1, 1, 1'b0};
        vecs[5]  = '{1'b1,1'b1,1'b0,1'b1,7'h01,5'd9, 32'h0000_0001, 1'b1,7'h42,5'd7, 32'haaaa,     1, 2, 1'b1};
        vecs[6]  = '{1'b1,1'b1,1'b0,1'b0,7'h01,5'd9, 32'h0000_0001, 1'b1,7'h42,5'd7, 32'haaaa,     1, 3, 1'b1};
        vecs[7]  = '{1'b1,1'b0,1'b0,1'b0,7'h20,5'd10,32'h0000_0077, 1'b0,7'h00,5'd0, 32'h0,        2, 3, 1'b0};
        vecs[8]  = '{1'b1,1'b0,1'b0,1'b0,7'h44,5'd11,32'h0000_0099, 1'b1,7'h44,5'd11,32'h99,       2, 3, 1'b0};
        vecs[9]  = '{1'b1,1'b1,1'b1,1'b0,7'h7f,5'd12,32'h0000_0005, 1'b1,7'h44,5'd11,32'h99,       2, 4, 1'b0};
        vecs[10] = '{1'b0,1'b1,1'b1,1'b0,7'h7f,5'd12,32'h0000_0005, 1'b0,7'h00,5'd0, 32'h0,        0, 0, 1'b0};
        vecs[11] = '{1'b1,1'b0,1'b1,1'b1,7'h7f,5'd13,32'h0000_0006, 1'b0,7'h00,5'd0, 32'h0,        1, 0, 1'b0};
        vecs[12] = '{1'b1,1'b1,1'b0,1'b1,7'h7f,5'd13,32'h0000_0006, 1'b0,7'h00,5'd0, 32'h0,        1, 1, 1'b1};
        vecs[13] = '{1'b1,1'b0,1'b1,1'b1,7'h7f,5'd14,32'h0000_0007, 1'b0,7'h00,5'd0, 32'h0,        2, 1, 1'b0};
        vecs[14] = '{1'b1,1'b0,1'b0,1'b0,7'h7f,5'd3, 32'hdead_beef, 1'b1,7'h7f,5'd3, 32'hdeadbeef, 2, 1, 1'b0};

        @(posedge clk);
        #1;

        for (int i = 0; i < 15; i++) begin
            drive(vecs[i].rst, vecs[i].stall, vecs[i].noop, vecs[i].flush,
                  vecs[i].ctrl, vecs[i].rd, vecs[i].data);
            step($sformatf("vec%0d", i));
            check($sformatf("vec%0d.t_valid", i), {31'd0, ex_valid}, {31'd0, vecs[i].e_valid});
            check($sformatf("vec%0d.t_ctrl", i), {25'd0, ex_ctrl}, {25'd0, vecs[i].e_ctrl});
            check($sformatf("vec%0d.t_rd", i), {27'd0, ex_rd}, {27'd0, vecs[i].e_rd});
            check($sformatf("vec%0d.t_rs1", i), ex_rs1d, vecs[i].e_data);
            check($sformatf("vec%0d.t_pend", i), {31'd0, flush_pend}, {31'd0, vecs[i].e_pend});
            check($sformatf("vec%0d.t_bub", i), {28'd0, bubble_cnt}, cnt_exp(vecs[i].e_bub));
            check($sformatf("vec%0d.t_hold", i), {28'd0, hold_cnt}, cnt_exp(vecs[i].e_hold));
        end

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            rst      = ($urandom_range(0, 39) != 0);
            stall    = ($urandom_range(0, 4) == 0);
            noop     = ($urandom_range(0, 5) == 0);
            flush    = ($urandom_range(0, 7) == 0);
            id_ctrl  = 7'($urandom);
            id_pc    = $urandom;
            id_rs1d  = $urandom;
            id_rs2d  = $urandom;
            id_imm   = $urandom;
            id_funct = 10'($urandom);
            id_rs1a  = 5'($urandom);
            id_rs2a  = 5'($urandom);
            id_rd    = 5'($urandom);
            step($sformatf("rnd%0d", i));
        end

        // Bubble counter saturation: 20 NoOp edges after reset
        drive(1'b0, 1'b0, 1'b0, 1'b0, 7'h00, 5'd0, 32'h0);
        step("sat_rst");
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, 1'b0, 1'b1, 1'b0, 7'h55, 5'd4, 32'h1111 * i);
            step($sformatf("sat_noop%0d", i));
        end
        check("sat_bubble_15", {28'd0, bubble_cnt}, cnt_exp(15));

        // Hold counter saturation, contents frozen through a long hold
        drive(1'b1, 1'b0, 1'b0, 1'b0, 7'h3c, 5'd21, 32'hcafe_f00d);
        step("sat_load");
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, 1'b1, 1'b1, i[0], 7'h0f, 5'd2, 32'h2222 * i);
            step($sformatf("sat_hold%0d", i));
        end
        check("sat_hold_15", {28'd0, hold_cnt}, cnt_exp(15));
        check("sat_hold_rd", {27'd0, ex_rd}, 32'd21);

        // Pending flush from the hold above becomes exactly one bubble
        drive(1'b1, 1'b0, 1'b0, 1'b0, 7'h0f, 5'd2, 32'h1);
        step("post_hold_bubble");
        check("post_hold_valid", {31'd0, ex_valid}, 32'd0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 7'h0f, 5'd2, 32'h1);
        step("post_hold_load");
        check("post_hold_rd", {27'd0, ex_rd}, 32'd2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
